monolith_bars_seq: RTL and testbench

- Time-multiplexed, handshaked Bars layer for the Monolith permutation over M31 (p = 2^31-1).
- Accepts a full state and applies the limb-wise S-box to the first BAR_OP_COUNT words, LANES words per cycle. It then emits the whole state reduced mod p.
- Sits between the round-constant/MDS stages in the round pipeline. The LANES parameter trades S-box area against latency.

---
 rtl/monolith_bars_seq.sv | 155 +++++++++++++++
 tb/tb_monolith_bars_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/monolith_bars_seq.sv
// Monolith Bars layer over M31: limb-wise S-box on the leading BAR_OP_COUNT words,
// LANES words per cycle, then the whole state is emitted reduced mod p.

module monolith_bars_sbox #(
  parameter int WORD_WIDTH = 31,
  parameter int LIMB_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] x,
  output logic [WORD_WIDTH-1:0] y
);
  localparam int NLIMB = (WORD_WIDTH + LIMB_WIDTH - 1) / LIMB_WIDTH;

  for (genvar l = 0; l < NLIMB; l++) begin : g_limb
    localparam int LO = l * LIMB_WIDTH;
    // The top limb carries whatever bits remain above the last full limb.
    localparam int WL = (LO + LIMB_WIDTH > WORD_WIDTH) ? (WORD_WIDTH - LO) : LIMB_WIDTH;
    localparam int K1 = 1 % WL;
    localparam int K2 = 2 % WL;
    localparam int K3 = 3 % WL;

    logic [WL-1:0] a, na, r1n, r2, r3, t, r1t;

    assign a   = x[LO +: WL];
    assign na  = ~a;
    assign r1n = (na << K1) | (na >> (WL - K1));
    assign r2  = (a << K2) | (a >> (WL - K2));
    assign r3  = (a << K3) | (a >> (WL - K3));
    assign t   = a ^ (r1n & r2 & r3);
    assign r1t = (t << K1) | (t >> (WL - K1));
    assign y[LO +: WL] = r1t;
  end
endmodule

module monolith_bars_seq #(
  parameter int WORD_WIDTH   = 31,
  parameter int STATE_SIZE   = 16,
  parameter int BAR_OP_COUNT = 8,
  parameter int LANES        = 2,
  parameter int LIMB_WIDTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out,
  output logic                                  busy
);
  localparam int ITERS = (LANES > 0) ? (BAR_OP_COUNT / LANES) : 1;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [WORD_WIDTH-1:0] P = {WORD_WIDTH{1'b1}};

  if (BAR_OP_COUNT < 1 || BAR_OP_COUNT > STATE_SIZE) begin : g_err_bar
    $error("BAR_OP_COUNT must be in 1..STATE_SIZE");
  end
  if (LANES < 1 || (BAR_OP_COUNT % LANES) != 0) begin : g_err_lanes
    $error("LANES must divide BAR_OP_COUNT");
  end
  if (LIMB_WIDTH < 1 || WORD_WIDTH < 1) begin : g_err_width
    $error("WORD_WIDTH and LIMB_WIDTH must be positive");
  end

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] work_q, work_d;
  logic [LANES-1:0][WORD_WIDTH-1:0]      lane_in, lane_out;

  // Select the LANES-word group addressed by cnt.
  always_comb begin
    lane_in = '0;
    for (int i = 0; i < ITERS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        for (int k = 0; k < LANES; k++) lane_in[k] = work_q[i*LANES + k];
      end
    end
  end

  monolith_bars_sbox #(
    .WORD_WIDTH(WORD_WIDTH),
    .LIMB_WIDTH(LIMB_WIDTH)
  ) u_sbox [LANES-1:0] (
    .x(lane_in),
    .y(lane_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        for (int i = 0; i < ITERS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            for (int k = 0; k < LANES; k++) work_d[i*LANES + k] = lane_out[k];
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // A waiting source is taken on the same edge the result leaves.
        if (out_ready) begin
          if (in_valid) begin
            work_d  = state_in;
            cnt_d   = '0;
            state_d = ITER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < STATE_SIZE; i++) begin
      state_out[i] = (work_q[i] == P) ? '0 : work_q[i];
    end
  end
endmodule

// File: tb/tb_monolith_bars_seq.sv
// Directed/random bench for monolith_bars_seq: default config plus a LANES=8,
// BAR_OP_COUNT=16 instance, checked against a per-limb arithmetic reference.

module tb_monolith_bars_seq;
  typedef logic [15:0][30:0] st_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_iv, a_ir, a_ov, a_or, a_busy;
  st_t  a_si, a_so;
  logic b_iv, b_ir, b_ov, b_or, b_busy;
  st_t  b_si, b_so;

  int compared = 0;
  int mismatched = 0;

  monolith_bars_seq u_dut_a (
    .clk(clk), .reset(rst_n),
    .in_valid(a_iv), .in_ready(a_ir), .state_in(a_si),
    .out_valid(a_ov), .out_ready(a_or), .state_out(a_so), .busy(a_busy)
  );

  monolith_bars_seq #(.BAR_OP_COUNT(16), .LANES(8)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .in_valid(b_iv), .in_ready(b_ir), .state_in(b_si),
    .out_valid(b_ov), .out_ready(b_or), .state_out(b_so), .busy(b_busy)
  );

  function automatic int unsigned rotl(int unsigned v, int n, int w);
    int unsigned m;
    m = (32'd1 << w) - 1;
    return ((v << n) | (v >> (w - n))) & m;
  endfunction

  function automatic logic [30:0] sbox_w(logic [30:0] x);
    int unsigned r, a, m, t;
    int w;
    r = 0;
    for (int l = 0; l < 4; l++) begin
      w = (l == 3) ? 7 : 8;
      m = (32'd1 << w) - 1;
      a = (32'(x) >> (8*l)) & m;
      t = a ^ (rotl(~a & m, 1, w) & rotl(a, 2, w) & rotl(a, 3, w));
      r = r | (rotl(t, 1, w) << (8*l));
    end
    return r[30:0];
  endfunction

  function automatic st_t model(st_t s, int bar);
    st_t o;
    logic [30:0] v;
    for (int i = 0; i < 16; i++) begin
      v = (i < bar) ? sbox_w(s[i]) : s[i];
      o[i] = (v == 31'h7FFF_FFFF) ? 31'd0 : v;
    end
    return o;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 16; i++)
      s[i] = ($urandom_range(0, 5) == 0) ? 31'h7FFF_FFFF : 31'($urandom());
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input st_t obs, input st_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept one state on the selected DUT and wait (bounded) for its result.
  task automatic txn(input bit sel, input st_t s, input int iters, input string tag);
    int lat;
    lat = 0;
    if (sel) begin b_iv = 1'b1; b_si = s; end
    else     begin a_iv = 1'b1; a_si = s; end
    chk({tag, "_ready"}, 32'(sel ? b_ir : a_ir), 32'd1);
    step();
    a_iv = 1'b0; b_iv = 1'b0;
    while ((sel ? !b_ov : !a_ov) && lat < 100) begin step(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'(iters));
    chk_st({tag, "_data"}, sel ? b_so : a_so, model(s, sel ? 16 : 8));
  endtask

  task automatic release_out(input bit sel, input string tag);
    if (sel) b_or = 1'b1; else a_or = 1'b1;
    step();
    a_or = 1'b0; b_or = 1'b0;
    chk({tag, "_ov_low"}, 32'(sel ? b_ov : a_ov), 32'd0);
    chk({tag, "_ir_high"}, 32'(sel ? b_ir : a_ir), 32'd1);
  endtask

  initial begin
    st_t s, q[$];
    int acc, outs, cyc, last_acc, lat;
    bit took;

    a_iv = 0; a_or = 0; a_si = '0;
    b_iv = 0; b_or = 0; b_si = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_ir", 32'(a_ir), 32'd1);
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk_st("rst_so", a_so, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed vector including fixed point and unreduced p words.
    s = '0;
    s[0] = 31'h1; s[1] = 31'h3; s[2] = 31'h0100_0000; s[3] = 31'h7FFF_FFFF;
    s[8] = 31'h7FFF_FFFF; s[9] = 31'd5;
    txn(1'b0, s, 4, "single");
    chk("single_w1", 32'(a_so[1]), 32'h16);
    chk("single_w2", 32'(a_so[2]), 32'h0200_0000);

    // Backpressure: result must hold with out_ready low.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_st("bp_hold", a_so, model(s, 8));
      chk("bp_ir", 32'(a_ir), 32'd0);
      chk("bp_busy", 32'(a_busy), 32'd0);
    end
    release_out(1'b0, "bp_rel");

    // Back-to-back streaming.
    a_iv = 1'b1; a_or = 1'b1; a_si = rand_st();
    acc = 0; outs = 0; cyc = 0; last_acc = -1;
    while ((acc < 6 || q.size() > 0) && cyc < 300) begin
      took = 1'b0;
      if (a_ov && a_or) begin
        chk("b2b_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk_st("b2b_data", a_so, q.pop_front());
        outs++;
      end
      if (a_iv && a_ir) begin
        q.push_back(model(a_si, 8));
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd5);
        last_acc = cyc; acc++; took = 1'b1;
      end
      step(); cyc++;
      if (acc >= 6) a_iv = 1'b0;
      else if (took) a_si = rand_st();
    end
    chk("b2b_count", 32'(outs), 32'd6);
    a_or = 1'b0;
    step();

    // Reset mid-ITER at cnt=2, then a clean transaction.
    a_iv = 1'b1; a_si = rand_st();
    step(); a_iv = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", 32'(a_ir), 32'd1);
    chk("mid_rst_ov", 32'(a_ov), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk_st("mid_rst_so", a_so, '0);
    step();
    rst_n = 1'b1;
    step();
    s = rand_st();
    txn(1'b0, s, 4, "post_rst");
    release_out(1'b0, "post_rst_rel");

    // Wide-lane instance: every word boxed, two iterations.
    for (int n = 0; n < 3; n++) begin
      s = rand_st();
      txn(1'b1, s, 2, "lanes8");
      release_out(1'b1, "lanes8_rel");
    end

    // in_valid toggling with junk data during ITER must be ignored.
    s = rand_st();
    a_iv = 1'b1; a_si = s;
    step();
    lat = 0;
    while (!a_ov && lat < 100) begin
      a_iv = 1'($urandom_range(0, 1));
      a_si = rand_st();
      step(); lat++;
    end
    a_iv = 1'b0;
    chk("tog_lat", 32'(lat), 32'd4);
    chk_st("tog_data", a_so, model(s, 8));
    release_out(1'b0, "tog_rel");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tog_single", 32'(a_ov), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
